// File: rtl/cmd_seq_arbiter_pkg.sv
// Shared encodings, command prefixes, FSM states and defaults for cmd_seq_arbiter.
// The optional WAIT_RDY timeout is enabled by defining CMD_ARB_TIMEOUT_EN.
package cmd_seq_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_HI,
    S_LO,
    S_FIN
  } state_e;

  localparam logic [15:0] PFX_WR0 = 16'hAF00;
  localparam logic [15:0] PFX_WR1 = 16'hAF01;
  localparam logic [31:0] CMD_WR_END = 32'hA000_0000;
  localparam logic [15:0] PFX_RD0 = 16'hAD00;
  localparam logic [15:0] PFX_RD1 = 16'hAD01;
  localparam logic [15:0] PFX_ER0 = 16'hAE00;
  localparam logic [15:0] PFX_ER1 = 16'hAE01;
  localparam logic [15:0] PFX_ER2 = 16'hAE02;
  localparam logic [15:0] PFX_ER3 = 16'hAE03;

  localparam int DEF_PULSE_HI    = 4;
  localparam int DEF_GAP_LO      = 4;
  localparam int DEF_TIMEOUT_CYC = 24000;

  // Index of the final word of each operation's word list.
  function automatic logic [1:0] last_word(op_e op);
    case (op)
      OP_WRITE: last_word = 2'd2;
      OP_READ:  last_word = 2'd1;
      OP_ERASE: last_word = 2'd3;
      default:  last_word = 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] cmd_word(op_e op, logic [1:0] idx,
                                           logic [23:0] sadr, logic [23:0] eadr);
    cmd_word = '0;
    case (op)
      OP_WRITE:
        case (idx)
          2'd0:    cmd_word = {PFX_WR0, sadr[23:8]};
          2'd1:    cmd_word = {PFX_WR1, sadr[7:0], 8'h00};
          default: cmd_word = CMD_WR_END;
        endcase
      OP_READ:
        case (idx)
          2'd0:    cmd_word = {PFX_RD0, sadr[23:8]};
          default: cmd_word = {PFX_RD1, sadr[7:0], 8'h00};
        endcase
      OP_ERASE:
        case (idx)
          2'd0:    cmd_word = {PFX_ER0, sadr[23:8]};
          2'd1:    cmd_word = {PFX_ER1, sadr[7:0], 8'h00};
          2'd2:    cmd_word = {PFX_ER2, eadr[23:8]};
          default: cmd_word = {PFX_ER3, eadr[7:0], 8'h00};
        endcase
      default: cmd_word = '0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_seq_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority flips
// to the other requester whenever a grant is taken.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  logic r_prio;  // requester that wins a tie

  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) o_gnt = r_prio ? 2'b10 : 2'b01;
    else                o_gnt = i_req;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                  r_prio <= 1'b0;
    else if (i_take && |i_req)  r_prio <= o_gnt[0];
  end

endmodule

// File: rtl/cmd_seq_arbiter.sv
// Arbitrates two requesters and plays the granted op out as strobed command words.
// Define CMD_ARB_TIMEOUT_EN to bound the flash_busy wait to TIMEOUT_CYC cycles.
module cmd_seq_arbiter
  import cmd_seq_arbiter_pkg::*;
#(
  parameter int PULSE_HI    = DEF_PULSE_HI,
  parameter int GAP_LO      = DEF_GAP_LO,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_op0,
  input  logic [1:0]  i_op1,
  input  logic [23:0] i_sadr0,
  input  logic [23:0] i_sadr1,
  input  logic [23:0] i_eadr0,
  input  logic [23:0] i_eadr1,
  input  logic        i_flash_busy,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_done,
  output logic        o_err,
  output logic [31:0] o_cmd,
  output logic        o_start_cmd
);

  localparam int PH_MAX = (PULSE_HI > GAP_LO) ? PULSE_HI : GAP_LO;
  localparam int PW     = $clog2(PH_MAX + 1);

  if (PULSE_HI < 1 || GAP_LO < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("cmd_seq_arbiter: PULSE_HI, GAP_LO and TIMEOUT_CYC must be >= 1");
  end

  state_e      r_state, w_next;
  logic [1:0]  r_gnt, w_arb_gnt;
  logic        w_take;
  op_e         r_op;
  logic [23:0] r_sadr, r_eadr;
  logic [1:0]  r_widx;
  logic [PW-1:0] r_ph_cnt;
  logic        r_err_flag;
  logic [31:0] r_cmd;
  logic        w_hi_end, w_lo_end, w_last, w_timeout;

  rr_arb2 u_arb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (i_req),
    .i_take (w_take),
    .o_gnt  (w_arb_gnt)
  );

  assign w_hi_end = (r_ph_cnt == PW'(PULSE_HI - 1));
  assign w_lo_end = (r_ph_cnt == PW'(GAP_LO - 1));
  assign w_last   = (r_widx == last_word(r_op));

`ifdef CMD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != S_WAIT_RDY) r_to_cnt <= '0;
    else                                r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      S_IDLE:     if (|i_req) begin
                    w_take = 1'b1;
                    w_next = S_WAIT_RDY;
                  end
      // A ready flash wins over a timeout landing on the same cycle.
      S_WAIT_RDY: if (r_op == OP_RSVD)    w_next = S_FIN;
                  else if (!i_flash_busy) w_next = S_HI;
                  else if (w_timeout)     w_next = S_FIN;
      S_HI:       if (w_hi_end) w_next = S_LO;
      S_LO:       if (w_lo_end) w_next = w_last ? S_FIN : S_HI;
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    o_gnt       = r_gnt;
    o_cmd       = r_cmd;
    o_start_cmd = (r_state == S_HI);
    o_done      = (r_state == S_FIN) ? r_gnt : 2'b00;
    o_err       = (r_state == S_FIN) && r_err_flag;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= 2'b00;
      r_op       <= OP_WRITE;
      r_sadr     <= '0;
      r_eadr     <= '0;
      r_widx     <= '0;
      r_ph_cnt   <= '0;
      r_err_flag <= 1'b0;
      r_cmd      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != w_next)                   r_ph_cnt <= '0;
      else if (r_state == S_HI || r_state == S_LO) r_ph_cnt <= r_ph_cnt + 1'b1;

      case (r_state)
        S_IDLE: if (w_take) begin
          r_gnt      <= w_arb_gnt;
          r_op       <= op_e'(w_arb_gnt[1] ? i_op1 : i_op0);
          r_sadr     <= w_arb_gnt[1] ? i_sadr1 : i_sadr0;
          r_eadr     <= w_arb_gnt[1] ? i_eadr1 : i_eadr0;
          r_widx     <= '0;
          r_err_flag <= 1'b0;
        end
        S_WAIT_RDY: begin
          if (w_next == S_HI)  r_cmd      <= cmd_word(r_op, 2'd0, r_sadr, r_eadr);
          if (w_next == S_FIN) r_err_flag <= 1'b1;
        end
        S_LO: if (w_next == S_HI) begin
          r_widx <= r_widx + 2'd1;
          r_cmd  <= cmd_word(r_op, r_widx + 2'd1, r_sadr, r_eadr);
        end
        S_FIN: r_gnt <= 2'b00;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_seq_arbiter.sv
// Directed bench for cmd_seq_arbiter: vector table for full sequences plus
// hand-written reserved-op, round-robin, busy, timeout and reset cases.
module tb_cmd_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  op0, op1;
  logic [23:0] sadr0, sadr1, eadr0, eadr1;
  logic        flash_busy;
  logic [1:0]  gnt, done;
  logic        err;
  logic [31:0] cmd;
  logic        start_cmd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cmd_seq_arbiter #(.PULSE_HI(4), .GAP_LO(4), .TIMEOUT_CYC(50)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .i_op0(op0), .i_op1(op1),
    .i_sadr0(sadr0), .i_sadr1(sadr1), .i_eadr0(eadr0), .i_eadr1(eadr1),
    .i_flash_busy(flash_busy),
    .o_gnt(gnt), .o_done(done), .o_err(err), .o_cmd(cmd), .o_start_cmd(start_cmd)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  op0, op1;
    logic [23:0] sadr0, eadr0, sadr1, eadr1;
    logic [1:0]  gnt;
    int          nw;
    logic [31:0] w[4];
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(logic [1:0] rq, logic [1:0] o0, logic [1:0] o1,
                              logic [23:0] s0, logic [23:0] e0,
                              logic [23:0] s1, logic [23:0] e1,
                              logic [1:0] g, int n,
                              logic [31:0] a, logic [31:0] b,
                              logic [31:0] c, logic [31:0] d);
    vec_t v;
    v.req = rq; v.op0 = o0; v.op1 = o1;
    v.sadr0 = s0; v.eadr0 = e0; v.sadr1 = s1; v.eadr1 = e1;
    v.gnt = g; v.nw = n;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_gnt"},   {30'd0, gnt},  32'd0);
    chk({name, "_done"},  {30'd0, done}, 32'd0);
    chk({name, "_err"},   {31'd0, err},  32'd0);
    chk({name, "_cmd"},   cmd,           32'd0);
    chk({name, "_start"}, {31'd0, start_cmd}, 32'd0);
  endtask

  // Drives one request, drops it after grant and scrambles the inputs to prove
  // latching, then checks every HI/LO cycle and the done pulse.
  task automatic run_txn(input vec_t v, input string name);
    req = v.req; op0 = v.op0; op1 = v.op1;
    sadr0 = v.sadr0; eadr0 = v.eadr0; sadr1 = v.sadr1; eadr1 = v.eadr1;
    flash_busy = 1'b0;
    step();
    chk({name, "_gnt"}, {30'd0, gnt}, {30'd0, v.gnt});
    chk({name, "_start0"}, {31'd0, start_cmd}, 32'd0);
    req = 2'b00; op0 = 2'b11; op1 = 2'b11;
    sadr0 = '0; sadr1 = '0; eadr0 = '0; eadr1 = '0;
    for (int k = 2; k <= 1 + 8 * v.nw; k++) begin
      int ph;
      step();
      ph = (k - 2) / 4;
      chk({name, "_start"}, {31'd0, start_cmd}, {31'd0, ((ph % 2) == 0)});
      if ((ph % 2) == 0) chk({name, "_cmd"}, cmd, v.w[ph / 2]);
      if (k == 1 + 8 * v.nw) chk({name, "_nodone"}, {30'd0, done}, 32'd0);
    end
    step();
    chk({name, "_done"}, {30'd0, done}, {30'd0, v.gnt});
    chk({name, "_err"}, {31'd0, err}, 32'd0);
    chk({name, "_fin_start"}, {31'd0, start_cmd}, 32'd0);
    step();
    chk({name, "_done_clr"}, {30'd0, done}, 32'd0);
    chk({name, "_gnt_clr"}, {30'd0, gnt}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] grants[3];
    logic [1:0] prev;
    int         ng;
    int         seen;
    int         bad;

    vecs[0] = mk(2'b01, 2'b00, 2'b00, 24'h010203, 24'h0, 24'h0, 24'h0, 2'b01, 3,
                 32'hAF000102, 32'hAF010300, 32'hA0000000, 32'h0);
    vecs[1] = mk(2'b10, 2'b00, 2'b10, 24'h0, 24'h0, 24'h010203, 24'h0A0B0C, 2'b10, 4,
                 32'hAE000102, 32'hAE010300, 32'hAE020A0B, 32'hAE030C00);
    vecs[2] = mk(2'b01, 2'b01, 2'b00, 24'hABCDEF, 24'h0, 24'h0, 24'h0, 2'b01, 2,
                 32'hAD00ABCD, 32'hAD01EF00, 32'h0, 32'h0);
    vecs[3] = mk(2'b10, 2'b00, 2'b00, 24'h0, 24'h0, 24'hFFFFFF, 24'h0, 2'b10, 3,
                 32'hAF00FFFF, 32'hAF01FF00, 32'hA0000000, 32'h0);
    vecs[4] = mk(2'b01, 2'b10, 2'b00, 24'h000000, 24'hFFFFFF, 24'h0, 24'h0, 2'b01, 4,
                 32'hAE000000, 32'hAE010000, 32'hAE02FFFF, 32'hAE03FF00);
    // Priority sits with requester 1 after vecs[4], so the tie goes to it.
    vecs[5] = mk(2'b11, 2'b00, 2'b01, 24'h111111, 24'h0, 24'h123456, 24'h0, 2'b10, 2,
                 32'hAD001234, 32'hAD015600, 32'h0, 32'h0);

    rst = 1'b1; req = 2'b00; op0 = 2'b00; op1 = 2'b00;
    sadr0 = '0; sadr1 = '0; eadr0 = '0; eadr1 = '0; flash_busy = 1'b0;
    @(negedge clk);
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk_all_zero("post_reset_idle");

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reserved op: err+done two cycles after the request, no words.
    req = 2'b01; op0 = 2'b11;
    step();
    chk("rsvd_gnt", {30'd0, gnt}, 32'd1);
    chk("rsvd_err_early", {31'd0, err}, 32'd0);
    req = 2'b00;
    step();
    chk("rsvd_err", {31'd0, err}, 32'd1);
    chk("rsvd_done", {30'd0, done}, 32'd1);
    chk("rsvd_start", {31'd0, start_cmd}, 32'd0);
    step();
    chk("rsvd_idle_err", {31'd0, err}, 32'd0);
    chk("rsvd_idle_gnt", {30'd0, gnt}, 32'd0);

    // Round-robin from reset with both requesters held.
    rst = 1'b1; step(); rst = 1'b0;
    req = 2'b11; op0 = 2'b01; op1 = 2'b01; sadr0 = 24'h000100; sadr1 = 24'h000200;
    ng = 0; prev = 2'b00;
    for (int c = 0; c < 200 && ng < 3; c++) begin
      step();
      if (gnt != 2'b00 && prev == 2'b00) begin
        grants[ng] = gnt;
        ng++;
      end
      prev = gnt;
    end
    req = 2'b00;
    chk("rr_count", ng, 3);
    if (ng == 3) begin
      chk("rr_first",  {30'd0, grants[0]}, 32'd1);
      chk("rr_second", {30'd0, grants[1]}, 32'd2);
      chk("rr_third",  {30'd0, grants[2]}, 32'd1);
    end
    repeat (30) step();
    chk("rr_idle", {30'd0, gnt}, 32'd0);

    // flash_busy held, then released; busy rising mid-sequence is ignored.
    flash_busy = 1'b1; req = 2'b01; op0 = 2'b00; sadr0 = 24'h010203;
    step();
    chk("busy_gnt", {30'd0, gnt}, 32'd1);
    req = 2'b00;
    bad = 0;
`ifdef CMD_ARB_TIMEOUT_EN
    repeat (29) begin step(); if (start_cmd || done != 2'b00) bad++; end
`else
    repeat (99) begin step(); if (start_cmd || done != 2'b00) bad++; end
`endif
    chk("busy_hold", bad, 0);
    flash_busy = 1'b0;
    step();
    chk("busy_rise", {31'd0, start_cmd}, 32'd1);
    chk("busy_word", cmd, 32'hAF000102);
    flash_busy = 1'b1;
    seen = 0;
    for (int c = 0; c < 60 && seen == 0; c++) begin
      step();
      if (done != 2'b00) seen = 1;
    end
    chk("busy_done_seen", seen, 1);
    chk("busy_done_val", {30'd0, done}, 32'd1);
    chk("busy_no_err", {31'd0, err}, 32'd0);
    flash_busy = 1'b0;
    step();

`ifdef CMD_ARB_TIMEOUT_EN
    flash_busy = 1'b1; req = 2'b01; op0 = 2'b00;
    step();
    chk("to_gnt", {30'd0, gnt}, 32'd1);
    req = 2'b00;
    bad = 0;
    repeat (49) begin step(); if (start_cmd || err || done != 2'b00) bad++; end
    chk("to_quiet", bad, 0);
    step();
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_done", {30'd0, done}, 32'd1);
    chk("to_start", {31'd0, start_cmd}, 32'd0);
    flash_busy = 1'b0;
    step();
    chk("to_idle", {30'd0, gnt}, 32'd0);
`endif

    // Reset during the second HI phase of a read.
    req = 2'b01; op0 = 2'b01; sadr0 = 24'h112233;
    step();
    chk("rstmid_gnt", {30'd0, gnt}, 32'd1);
    req = 2'b00;
    repeat (9) step();
    chk("rstmid_hi2", {31'd0, start_cmd}, 32'd1);
    chk("rstmid_word", cmd, 32'hAD013300);
    rst = 1'b1;
    step();
    chk_all_zero("rstmid");
    rst = 1'b0;
    bad = 0;
    repeat (5) begin step(); if (done != 2'b00 || gnt != 2'b00 || start_cmd) bad++; end
    chk("rstmid_quiet", bad, 0);
    run_txn(vecs[0], "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
